// File: rtl/comp_edge_pkg.sv
// Shared types and mux codes for the two-input edge arrival-order resolver.
package comp_edge_pkg;

   typedef enum logic [1:0] {
      ARMED  = 2'd0,
      X_LEAD = 2'd1,
      Y_LEAD = 2'd2,
      TIE    = 2'd3
   } state_e;

   localparam logic [2:0] SEL_NONE = 3'b000;
   localparam logic [2:0] SEL_X    = 3'b001;
   localparam logic [2:0] SEL_Y    = 3'b010;
   localparam logic [2:0] SEL_TIE  = 3'b100;

   function automatic logic [2:0] sel_for_state(input state_e state);
      logic [2:0] sel;
      sel = SEL_NONE;
      case (state)
         ARMED:   sel = SEL_NONE;
         X_LEAD:  sel = SEL_X;
         Y_LEAD:  sel = SEL_Y;
         TIE:     sel = SEL_TIE;
         default: sel = SEL_NONE;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/comp_edge_det.sv
// Per-input sampler and rising-edge detector; optional input synchronizer
// enabled by defining COMP_EDGE_SYNC_EN (depth SYNC_STAGES, 2..4).
module comp_edge_det
   import comp_edge_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_b,
   input  logic din,
   output logic level,
   output logic rise
);

   logic prev_q;
   logic prev_d;

   if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
      $error("comp_edge_det: SYNC_STAGES must be 2..4");
   end

`ifdef COMP_EDGE_SYNC_EN
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], din};
   end

   // Chain resets high so a line already high at release is not a rise.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         sync_q <= '1;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];
`else
   assign level = din;
`endif

   always_comb begin
      prev_d = level;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= prev_d;
      end
   end

   assign rise = level & ~prev_q;

endmodule

// File: rtl/comp_edge_resolve.sv
// Resolves which of x_edge / y_edge rose first and drives a registered one-hot
// mux select; COMP_EDGE_SYNC_EN adds a SYNC_STAGES-deep input synchronizer.
module comp_edge_resolve
   import comp_edge_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst_b,
   input  logic       x_edge,
   input  logic       y_edge,
   output logic [2:0] to_sel_mux
);

   logic   x_level;
   logic   x_rise;
   logic   y_level;
   logic   y_rise;
   state_e state_q;
   state_e state_d;
   logic [2:0] sel_q;
   logic [2:0] sel_d;

   comp_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_det_x (
      .clk   (clk),
      .rst_b (rst_b),
      .din   (x_edge),
      .level (x_level),
      .rise  (x_rise)
   );

   comp_edge_det #(.SYNC_STAGES(SYNC_STAGES)) u_det_y (
      .clk   (clk),
      .rst_b (rst_b),
      .din   (y_edge),
      .level (y_level),
      .rise  (y_rise)
   );

   // Once a decision is taken it is held until both lines are seen low.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ARMED: begin
            if (x_rise && y_rise) begin
               state_d = TIE;
            end else if (x_rise) begin
               state_d = X_LEAD;
            end else if (y_rise) begin
               state_d = Y_LEAD;
            end
         end
         X_LEAD, Y_LEAD, TIE: begin
            if (!x_level && !y_level) begin
               state_d = ARMED;
            end
         end
         default: state_d = ARMED;
      endcase
      sel_d = sel_for_state(state_d);
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= ARMED;
         sel_q   <= SEL_NONE;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
      end
   end

   assign to_sel_mux = sel_q;

endmodule

// File: tb/tb_comp_edge_resolve.sv
// Directed self-checking bench for comp_edge_resolve in its default
// (unsynchronized, 1-cycle latency) build.
module tb_comp_edge_resolve;

   logic       clk;
   logic       rst_b;
   logic       x_edge;
   logic       y_edge;
   logic [2:0] to_sel_mux;

   int checks;
   int fails;

   comp_edge_resolve #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rst_b      (rst_b),
      .x_edge     (x_edge),
      .y_edge     (y_edge),
      .to_sel_mux (to_sel_mux)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one posedge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_b  = 1'b0;
      x_edge = 1'b0;
      y_edge = 1'b0;
      tick();
      tick();
      rst_b = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_b  = 1'b0;
      x_edge = 1'b1;
      y_edge = 1'b1;
      #2;
      checks++;
      if (to_sel_mux !== 3'b000) begin
         $display("[TB] FAIL reset_async got=%b exp=%b", to_sel_mux, 3'b000);
         fails++;
      end
      tick();
      checks++;
      if (to_sel_mux !== 3'b000) begin
         $display("[TB] FAIL reset_held got=%b exp=%b", to_sel_mux, 3'b000);
         fails++;
      end
      x_edge = 1'b0;
      y_edge = 1'b0;
      tick();
      rst_b = 1'b1;
      tick();
   endtask

   task automatic test_x_lead();
      logic [2:0] exp_seq [6];
      logic       x_seq   [6];
      exp_seq = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b001, 3'b000};
      x_seq   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         x_edge = x_seq[i];
         y_edge = 1'b0;
         tick();
         checks++;
         if (to_sel_mux !== exp_seq[i]) begin
            $display("[TB] FAIL x_lead step%0d got=%b exp=%b", i, to_sel_mux, exp_seq[i]);
            fails++;
         end
      end
   endtask

   task automatic test_y_lead();
      logic [2:0] exp_seq [7];
      logic       x_seq   [7];
      logic       y_seq   [7];
      exp_seq = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b000};
      x_seq   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
      y_seq   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 7; i++) begin
         x_edge = x_seq[i];
         y_edge = y_seq[i];
         tick();
         checks++;
         if (to_sel_mux !== exp_seq[i]) begin
            $display("[TB] FAIL y_lead step%0d got=%b exp=%b", i, to_sel_mux, exp_seq[i]);
            fails++;
         end
      end
   endtask

   task automatic test_tie_and_back_to_back();
      logic [2:0] exp_seq [9];
      logic       x_seq   [9];
      logic       y_seq   [9];
      // tie, return, immediate x rise, 1-cycle y pulse, y lead with x rising as y falls
      exp_seq = '{3'b100, 3'b000, 3'b001, 3'b000, 3'b010, 3'b000, 3'b010, 3'b010, 3'b000};
      x_seq   = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      y_seq   = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 9; i++) begin
         x_edge = x_seq[i];
         y_edge = y_seq[i];
         tick();
         checks++;
         if (to_sel_mux !== exp_seq[i]) begin
            $display("[TB] FAIL tie_b2b step%0d got=%b exp=%b", i, to_sel_mux, exp_seq[i]);
            fails++;
         end
      end
   endtask

   task automatic test_high_at_release();
      logic [2:0] exp_seq [4];
      logic       x_seq   [4];
      exp_seq = '{3'b000, 3'b000, 3'b000, 3'b001};
      x_seq   = '{1'b1, 1'b1, 1'b0, 1'b1};
      rst_b  = 1'b0;
      x_edge = 1'b1;
      y_edge = 1'b0;
      tick();
      rst_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         x_edge = x_seq[i];
         tick();
         checks++;
         if (to_sel_mux !== exp_seq[i]) begin
            $display("[TB] FAIL high_at_release step%0d got=%b exp=%b", i, to_sel_mux, exp_seq[i]);
            fails++;
         end
      end
   endtask

   task automatic test_reset_mid_decision();
      checks++;
      if (to_sel_mux !== 3'b001) begin
         $display("[TB] FAIL mid_reset_pre got=%b exp=%b", to_sel_mux, 3'b001);
         fails++;
      end
      rst_b = 1'b0;
      #1;
      checks++;
      if (to_sel_mux !== 3'b000) begin
         $display("[TB] FAIL mid_reset_async got=%b exp=%b", to_sel_mux, 3'b000);
         fails++;
      end
      x_edge = 1'b0;
      tick();
      rst_b = 1'b1;
      tick();
      checks++;
      if (to_sel_mux !== 3'b000) begin
         $display("[TB] FAIL mid_reset_after got=%b exp=%b", to_sel_mux, 3'b000);
         fails++;
      end
      y_edge = 1'b1;
      tick();
      checks++;
      if (to_sel_mux !== 3'b010) begin
         $display("[TB] FAIL mid_reset_fresh got=%b exp=%b", to_sel_mux, 3'b010);
         fails++;
      end
      y_edge = 1'b0;
      tick();
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      rst_b  = 1'b0;
      x_edge = 1'b0;
      y_edge = 1'b0;
      test_reset();
      test_x_lead();
      test_y_lead();
      test_tie_and_back_to_back();
      test_high_at_release();
      test_reset_mid_decision();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
